pipe_sequencer: RTL and testbench

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

---
 rtl/pipe_seq_pkg.sv | 12 +
 rtl/pipe_sequencer_sat_counter.sv | 25 ++
 rtl/pipe_sequencer.sv | 139 +++++++++++++
 tb/tb_pipe_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_seq_pkg.sv
// Shared types and widths for the pipeline sequencer.
// Used by pipe_sequencer and sat_counter.
package pipe_seq_pkg;
    localparam int STATE_W = 2;
    localparam int CNT_W   = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;
endpackage

// File: rtl/pipe_sequencer_sat_counter.sv
// Saturating up-counter with enable and async active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter
    import pipe_seq_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] r_cnt;

    // Count enabled cycles, sticking at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;
endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline stall/flush/halt sequencer with optional perf counters.
// Define PIPE_SEQ_PERF_EN to build the stall/flush/freeze counters.
module pipe_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_haz,
    input  logic             br_taken,
    input  logic             hlt_id,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);
    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

    seq_state_e    r_state;
    logic [DW-1:0] r_drain;
    logic          r_halted;

    logic w_freeze;
    logic w_run;
    logic w_run_br;
    logic w_run_lu;
    logic w_run_hlt;

    // Freeze is independent of state; events only act in unfrozen RUN
    assign w_freeze  = mem_req & ~mem_ack;
    assign w_run     = (r_state == ST_RUN) & ~w_freeze;
    assign w_run_br  = w_run & br_taken;
    assign w_run_lu  = w_run & ~br_taken & load_use_haz;
    assign w_run_hlt = w_run & ~br_taken & ~load_use_haz & hlt_id;

    // Stage enables and bubbles are zero-latency from state and inputs
    always_comb begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!w_freeze) begin
            case (r_state)
                ST_RUN: begin
                    pc_we     = ~w_run_lu;
                    if_id_we  = ~w_run_lu;
                    id_ex_we  = 1'b1;
                    ex_mem_we = 1'b1;
                    mem_wb_we = 1'b1;
                    if_id_flush = w_run_br;
                    id_ex_flush = w_run_br | w_run_lu;
                end
                ST_DRAIN: begin
                    id_ex_we    = 1'b1;
                    ex_mem_we   = 1'b1;
                    mem_wb_we   = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer FSM: RUN -> DRAIN -> HALTED, frozen cycles hold everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_drain  <= '0;
            r_halted <= 1'b0;
        end else if (!w_freeze) begin
            case (r_state)
                ST_RUN: begin
                    if (w_run_hlt) begin
                        if (DRAIN_CYCLES == 0) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_drain <= DRAIN_INIT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((r_drain == DW'(1)) || (r_drain == '0)) begin
                        r_state  <= ST_HALTED;
                        r_drain  <= '0;
                        r_halted <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted = r_halted;

`ifdef PIPE_SEQ_PERF_EN
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (w_run_lu),
        .cnt   (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (w_run_br),
        .cnt   (flush_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (w_freeze),
        .cnt   (freeze_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign freeze_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_sequencer.sv
// Randomized self-checking bench for pipe_sequencer.
// Expected counter values depend on PIPE_SEQ_PERF_EN.
module tb_pipe_sequencer;
    localparam int D = 3;
`ifdef PIPE_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        load_use_haz;
    logic        br_taken;
    logic        hlt_id;
    logic        mem_req;
    logic        mem_ack;
    logic        pc_we;
    logic        if_id_we;
    logic        id_ex_we;
    logic        ex_mem_we;
    logic        mem_wb_we;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] freeze_cnt;

    pipe_sequencer #(.DRAIN_CYCLES(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_use_haz (load_use_haz),
        .br_taken     (br_taken),
        .hlt_id       (hlt_id),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .id_ex_we     (id_ex_we),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .freeze_cnt   (freeze_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: mode 0=running, 1=draining, 2=halted
    int m_mode;
    int m_left;
    int m_stall;
    int m_flush;
    int m_freeze;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] perf_val(input int n);
        if (!PERF) return 32'd0;
        return (n > 65535) ? 32'd65535 : 32'(n);
    endfunction

    function automatic logic [7:0] outs_now();
        return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                if_id_flush, id_ex_flush, halted};
    endfunction

    // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, halted}
    function automatic logic [7:0] exp_outs(input logic lu, br, mr, ma);
        logic h;
        h = (m_mode == 2);
        if (mr && !ma)  return {7'b0000000, h};
        if (m_mode == 2) return {7'b0000000, h};
        if (m_mode == 1) return {7'b0011101, h};
        if (br)         return {7'b1111111, h};
        if (lu)         return {7'b0011101, h};
        return {7'b1111100, h};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_stall = 0;
        m_flush = 0;
        m_freeze = 0;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, ".stall"},  32'(stall_cnt),  perf_val(m_stall));
        check({tag, ".flush"},  32'(flush_cnt),  perf_val(m_flush));
        check({tag, ".freeze"}, 32'(freeze_cnt), perf_val(m_freeze));
    endtask

    // one clock: drive, check mid-cycle, then advance the model
    task automatic cycle(input logic lu, br, hl, mr, ma);
        load_use_haz = lu;
        br_taken = br;
        hlt_id = hl;
        mem_req = mr;
        mem_ack = ma;
        #3;
        check("outs", 32'(outs_now()), 32'(exp_outs(lu, br, mr, ma)));
        check_cnts("cnt");
        @(posedge clk);
        #1;
        if (mr && !ma) begin
            m_freeze++;
        end else if (m_mode == 0) begin
            if (br) m_flush++;
            else if (lu) m_stall++;
            else if (hl) begin
                if (D == 0) m_mode = 2;
                else begin
                    m_mode = 1;
                    m_left = D;
                end
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end
    endtask

    // async reset pulse placed mid-cycle
    task automatic do_reset();
        load_use_haz = 0;
        br_taken = 0;
        hlt_id = 0;
        mem_req = 0;
        mem_ack = 0;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst.outs", 32'(outs_now()), 32'h000000F8);
        check_cnts("rst");
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        while (!halted && n < 40) begin
            cycle(0, 0, 0, 0, 0);
            n++;
        end
    endtask

    int n;

    initial begin
        rst = 1'b1;
        load_use_haz = 0;
        br_taken = 0;
        hlt_id = 0;
        mem_req = 0;
        mem_ack = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // single load-use bubble
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("lu.stall", 32'(stall_cnt), PERF ? 32'd1 : 32'd0);

        // branch overrides hazard
        do_reset();
        cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("br.flush", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
        check("br.stall", 32'(stall_cnt), 32'd0);
        check("br.halted", 32'(halted), 32'd0);

        // halt drain: 3 drain cycles, halted visible at the 5th cycle
        do_reset();
        cycle(0, 0, 1, 0, 0);
        wait_halt(n);
        check("drain.len", 32'(n), 32'd3);
        cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 1);

        // reset while halted
        do_reset();
        check("rst.halted", 32'(halted), 32'd0);

        // freeze for 4 cycles mid-drain
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
        wait_halt(n);
        check("frz.rest", 32'(n), 32'd2);
        check("frz.cnt", 32'(freeze_cnt), PERF ? 32'd4 : 32'd0);

        // randomized traffic with occasional reset
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0 ||
                (m_mode == 2 && $urandom_range(0, 19) == 0))
                do_reset();
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
                  1'($urandom_range(0, 1)));
        end

        // saturation of the stall counter
        do_reset();
        for (int i = 0; i < 70000; i++) cycle(1, 0, 0, 0, 0);
        check("sat.stall", 32'(stall_cnt), PERF ? 32'h0000FFFF : 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
